// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive controller: FSM encoding,
// default bus addresses, status bit positions and a ceil-log2 helper.
package uart_rx_ctrl_pkg;

   typedef enum logic [1:0] {
      WAIT_FLAG = 2'd0,
      CAPTURE   = 2'd1,
      CLEAR     = 2'd2,
      WAIT_DROP = 2'd3
   } rx_state_t;

   localparam logic [31:0] DEF_ADDR_DATA = 32'h1001_0028;
   localparam logic [31:0] DEF_ADDR_STAT = 32'h1001_002C;

   localparam int ST_AVAIL = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_OVR   = 2;
   localparam int ST_TMO   = 3;

   function automatic int CeilLog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < value) r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// rx_byte_fifo: small synchronous FIFO holding received bytes.
// A push while full is accepted only when a pop happens in the same cycle.
module rx_byte_fifo
   import uart_rx_ctrl_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [CeilLog2(DEPTH):0] count
);

   localparam int AW = CeilLog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: captures bytes from the receiver core into a FIFO
// and exposes data/status registers. Optional idle timeout: UART_RX_TIMEOUT_EN.
module uart_rx_ctrl
   import uart_rx_ctrl_pkg::*;
#(
   parameter int          NBIT        = 8,
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [31:0] ADDR_DATA   = DEF_ADDR_DATA,
   parameter logic [31:0] ADDR_STAT   = DEF_ADDR_STAT,
   parameter int          TIMEOUT_CYC = 100
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx_flag,
   input  logic [NBIT-1:0] rx_data,
   output logic            clr_rx_flag,
   input  logic [31:0]     addr,
   input  logic            rd_en,
   input  logic            wr_en,
   input  logic [31:0]     wdata,
   output logic [31:0]     rdata,
   output logic            irq
);

   localparam int CW = CeilLog2(FIFO_DEPTH) + 1;

   rx_state_t       state;
   rx_state_t       next_state;
   logic            capture;
   logic            pop;
   logic            push_ok;
   logic            ovr_set;
   logic            ovr_clr;
   logic            tmo_clr;
   logic            overrun;
   logic            tmo;
   logic            full;
   logic            empty;
   logic [CW-1:0]   count;
   logic [NBIT-1:0] head;
   logic [3:0]      cnt_field;
   logic [31:0]     status;
   logic            stat_wr;

   // Capture FSM: state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= WAIT_FLAG;
      else        state <= next_state;
   end

   // Capture FSM: next state. WAIT_DROP holds until the core drops its flag
   // so a flag that lingers after the clear pulse is not captured twice.
   always_comb begin
      next_state = state;
      case (state)
         WAIT_FLAG: if (rx_flag) next_state = CAPTURE;
         CAPTURE:   next_state = CLEAR;
         CLEAR:     next_state = WAIT_DROP;
         WAIT_DROP: if (!rx_flag) next_state = WAIT_FLAG;
         default:   next_state = WAIT_FLAG;
      endcase
   end

   // Capture FSM: outputs
   always_comb begin
      capture     = 1'b0;
      clr_rx_flag = 1'b1;
      case (state)
         CAPTURE: capture     = 1'b1;
         CLEAR:   clr_rx_flag = 1'b0;
         default: ;
      endcase
   end

   assign pop     = rd_en && (addr == ADDR_DATA) && !empty;
   assign push_ok = capture && (!full || pop);
   assign ovr_set = capture && full && !pop;
   assign stat_wr = wr_en && (addr == ADDR_STAT);
   assign ovr_clr = stat_wr && wdata[ST_OVR];
   assign tmo_clr = stat_wr && wdata[ST_TMO];

   rx_byte_fifo #(
      .W     (NBIT),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (capture),
      .pop   (pop),
      .din   (rx_data),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Overrun is sticky; a set in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       overrun <= 1'b0;
      else if (ovr_set) overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
   end

`ifdef UART_RX_TIMEOUT_EN
   localparam int TW = CeilLog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] idle_cnt;
   logic          idle;
   logic          tmo_set;

   assign idle    = !empty && !push_ok && !pop;
   assign tmo_set = idle && (idle_cnt == TW'(TIMEOUT_CYC - 1));

   // Counter saturates so a cleared timeout is not re-raised by the same idle stretch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                              idle_cnt <= '0;
      else if (!idle)                          idle_cnt <= '0;
      else if (idle_cnt != TW'(TIMEOUT_CYC))   idle_cnt <= idle_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       tmo <= 1'b0;
      else if (tmo_set) tmo <= 1'b1;
      else if (tmo_clr) tmo <= 1'b0;
   end
`else
   localparam int unused_timeout_cyc = TIMEOUT_CYC;
   logic unused_tmo_clr;

   assign tmo            = 1'b0;
   assign unused_tmo_clr = tmo_clr;
`endif

   logic unused_wdata;
   assign unused_wdata = &{1'b0, wdata[31:4], wdata[1:0]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) irq <= 1'b0;
      else        irq <= !empty || tmo;
   end

   always_comb begin
      if (32'(count) > 15) cnt_field = 4'hF;
      else                 cnt_field = 4'(count);
   end

   always_comb begin
      status           = '0;
      status[ST_AVAIL] = !empty;
      status[ST_FULL]  = full;
      status[ST_OVR]   = overrun;
      status[ST_TMO]   = tmo;
      status[7:4]      = cnt_field;
   end

   always_comb begin
      rdata = '0;
      if (addr == ADDR_DATA) begin
         if (!empty) rdata = 32'(head);
      end else if (addr == ADDR_STAT) begin
         rdata = status;
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl; build with +define+UART_RX_TIMEOUT_EN to
// expect the idle-timeout status bit.
module tb_uart_rx_ctrl;
   import uart_rx_ctrl_pkg::*;

   localparam logic [31:0] A_DATA  = 32'h1001_0028;
   localparam logic [31:0] A_STAT  = 32'h1001_002C;
   localparam logic [31:0] A_OTHER = 32'h1001_0030;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_flag;
   logic [7:0]  rx_data;
   logic        clr_rx_flag;
   logic [31:0] addr;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int checks = 0;
   int errors = 0;

   uart_rx_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .rx_flag     (rx_flag),
      .rx_data     (rx_data),
      .clr_rx_flag (clr_rx_flag),
      .addr        (addr),
      .rd_en       (rd_en),
      .wr_en       (wr_en),
      .wdata       (wdata),
      .rdata       (rdata),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_stat(input string tag, input logic [31:0] exp);
      addr  = A_STAT;
      rd_en = 1'b0;
      #1;
      check(tag, rdata, exp);
   endtask

   task automatic pop_data(input string tag, input logic [31:0] exp);
      @(negedge clk);
      addr  = A_DATA;
      rd_en = 1'b1;
      #1;
      check(tag, rdata, exp);
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      addr  = a;
      wdata = d;
      wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      wdata = '0;
   endtask

   // Models the receiver core: flag held until the clear pulse, optionally longer.
   task automatic send_byte(input logic [7:0] b, input int hold);
      int lows;
      int held;
      bit seen;
      lows = 0;
      held = 0;
      seen = 0;
      @(negedge clk);
      rx_flag = 1'b1;
      rx_data = b;
      for (int i = 0; i < 8 + hold; i++) begin
         @(negedge clk);
         if (clr_rx_flag === 1'b0) begin
            lows++;
            seen = 1;
         end
         if (seen) begin
            if (held < hold) begin
               held++;
               rx_data = b + 8'd1;
               if (held == 5) check("stuck_wait_drop", 32'(dut.state), 32'(WAIT_DROP));
            end else begin
               rx_flag = 1'b0;
            end
         end
      end
      check("clr_pulse_len", lows, 1);
   endtask

   initial begin
      reset   = 1'b0;
      rx_flag = 1'b0;
      rx_data = '0;
      addr    = A_DATA;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      wdata   = '0;
      #1;
      check("reset_clr", 32'(clr_rx_flag), 32'd1);
      check("reset_irq", 32'(irq), 32'd0);
      check("reset_data", rdata, 32'd0);
      check_stat("reset_stat", 32'h00);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Single byte
      send_byte(8'hA5, 0);
      check_stat("single_stat", 32'h11);
      check("single_irq", 32'(irq), 32'd1);
      addr  = A_OTHER;
      rd_en = 1'b1;
      #1;
      check("other_addr", rdata, 32'd0);
      @(negedge clk);
      rd_en = 1'b0;
      bus_write(A_DATA, 32'hFF);
      check_stat("after_ignored", 32'h11);
      pop_data("single_pop", 32'hA5);
      check_stat("single_empty", 32'h00);
      @(negedge clk);
      check("single_irq_off", 32'(irq), 32'd0);
      pop_data("empty_pop", 32'h00);
      check_stat("empty_pop_stat", 32'h00);

      // Fill
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 0);
      check_stat("fill_stat", 32'h43);
      for (int i = 1; i <= 4; i++) pop_data("fill_pop", 32'(i));
      check_stat("fill_empty", 32'h00);

      // Overrun
      for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 0);
      send_byte(8'h55, 0);
      check_stat("ovr_stat", 32'h47);
      check("ovr_irq", 32'(irq), 32'd1);
      bus_write(A_STAT, 32'h4);
      check_stat("ovr_cleared", 32'h43);
      for (int i = 0; i < 4; i++) pop_data("ovr_pop", 32'h11 + 32'(i));
      check_stat("ovr_empty", 32'h00);

      // Simultaneous push and pop while full
      for (int i = 0; i < 4; i++) send_byte(8'h21 + 8'(i), 0);
      @(negedge clk);
      rx_flag = 1'b1;
      rx_data = 8'h25;
      @(negedge clk);
      addr  = A_DATA;
      rd_en = 1'b1;
      #1;
      check("simul_head", rdata, 32'h21);
      @(negedge clk);
      rd_en = 1'b0;
      check("simul_clr", 32'(clr_rx_flag), 32'd0);
      rx_flag = 1'b0;
      repeat (3) @(negedge clk);
      check_stat("simul_stat", 32'h43);
      for (int i = 0; i < 4; i++) pop_data("simul_pop", 32'h22 + 32'(i));
      check_stat("simul_empty", 32'h00);

      // Stuck flag
      send_byte(8'h77, 10);
      check_stat("stuck_stat", 32'h11);
      pop_data("stuck_pop", 32'h77);
      check_stat("stuck_empty", 32'h00);

      // Idle timeout
      send_byte(8'h99, 0);
      repeat (40) @(negedge clk);
      check_stat("tmo_early", 32'h11);
      repeat (70) @(negedge clk);
`ifdef UART_RX_TIMEOUT_EN
      check_stat("tmo_set", 32'h19);
`else
      check_stat("tmo_absent", 32'h11);
`endif
      check("tmo_irq", 32'(irq), 32'd1);
      bus_write(A_STAT, 32'h8);
      check_stat("tmo_cleared", 32'h11);
      pop_data("tmo_pop", 32'h99);
      @(negedge clk);
      check("tmo_irq_off", 32'(irq), 32'd0);

      // Reset mid-frame
      send_byte(8'h3C, 0);
      @(negedge clk);
      rx_flag = 1'b1;
      rx_data = 8'h5A;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_stat("midreset_stat", 32'h00);
      check("midreset_clr", 32'(clr_rx_flag), 32'd1);
      check("midreset_irq", 32'(irq), 32'd0);
      rx_flag = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_stat("post_reset_stat", 32'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
